// File: rtl/div2_sequencer.sv
// Fixed-point divide sequencer: reads dividend/divisor bytes, writes floor(dividend*256/divisor) as 3 bytes.
// Start 1-then-0 launches a run; Ack holds until the next Start=1. Start is ignored while Busy.
module div2_sequencer #(
  parameter logic [7:0] IN_BASE  = 8'd0,
  parameter logic [7:0] OUT_BASE = 8'd4,
  parameter int         QBITS    = 24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic       Busy,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemDataOut,
  input  logic [7:0] MemDataIn
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [3:0] {
    IDLE, RD_HI, RD_LO, RD_DIV, CAPT, DIVIDE, WR0, WR1, WR2, DONE
  } state_t;

  state_t           state;
  logic             armed;
  logic [7:0]       hi;
  logic [7:0]       lo;
  logic [7:0]       d;
  logic [7:0]       r;
  logic [QBITS-1:0] n;
  logic [QBITS-1:0] q;
  logic [CW-1:0]    cnt;

  // The remainder is always below D after each step, so 8 stored bits suffice;
  // the 9th bit only exists in the shifted trial value.
  logic [8:0]       r9;
  logic             qbit;
  logic [7:0]       r_sub;
  logic [QBITS-1:0] q_next;

  assign r9     = {r, n[QBITS-1]};
  assign qbit   = (r9 >= {1'b0, d});
  assign r_sub  = r9[7:0] - d;
  assign q_next = {q[QBITS-2:0], qbit};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      d          <= '0;
      r          <= '0;
      n          <= '0;
      q          <= '0;
      cnt        <= '0;
      Ack        <= 1'b0;
      Busy       <= 1'b0;
      MemAddr    <= '0;
      MemWrEn    <= 1'b0;
      MemDataOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (armed && !Start) begin
            armed   <= 1'b0;
            state   <= RD_HI;
            Busy    <= 1'b1;
            MemAddr <= IN_BASE;
          end else if (Start) begin
            armed <= 1'b1;
          end
        end
        RD_HI: begin
          state   <= RD_LO;
          MemAddr <= IN_BASE + 8'd1;
        end
        RD_LO: begin
          hi      <= MemDataIn;
          state   <= RD_DIV;
          MemAddr <= IN_BASE + 8'd2;
        end
        RD_DIV: begin
          lo    <= MemDataIn;
          state <= CAPT;
        end
        CAPT: begin
          d <= MemDataIn;
          if (MemDataIn == 8'd0) begin
            q          <= '1;
            state      <= WR0;
            MemAddr    <= OUT_BASE;
            MemDataOut <= 8'hFF;
            MemWrEn    <= 1'b1;
          end else begin
            n     <= {hi, lo, 8'h00};
            r     <= '0;
            q     <= '0;
            cnt   <= CW'(QBITS - 1);
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          r   <= qbit ? r_sub : r9[7:0];
          q   <= q_next;
          n   <= {n[QBITS-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state      <= WR0;
            MemAddr    <= OUT_BASE;
            MemDataOut <= q_next[23:16];
            MemWrEn    <= 1'b1;
          end
        end
        WR0: begin
          state      <= WR1;
          MemAddr    <= OUT_BASE + 8'd1;
          MemDataOut <= q[15:8];
        end
        WR1: begin
          state      <= WR2;
          MemAddr    <= OUT_BASE + 8'd2;
          MemDataOut <= q[7:0];
        end
        WR2: begin
          state   <= DONE;
          MemWrEn <= 1'b0;
          Busy    <= 1'b0;
          Ack     <= 1'b1;
        end
        DONE: begin
          if (Start) begin
            Ack   <= 1'b0;
            armed <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div2_sequencer.sv
// Bench for div2_sequencer: byte memory model, scoreboard of expected writes and results per launch.
module tb_div2_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic       Busy;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemDataOut;
  logic [7:0] MemDataIn;

  div2_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Busy(Busy),
    .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemDataOut(MemDataOut), .MemDataIn(MemDataIn)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] mem [256];
  logic [7:0] mem_rd;
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_dat;

  always @(posedge Clk) begin
    if (tb_we) mem[tb_addr] <= tb_dat;
    else if (MemWrEn) mem[MemAddr] <= MemDataOut;
    mem_rd <= mem[MemAddr];
  end
  assign MemDataIn = mem_rd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [15:0] wr_q [$];
  logic [23:0] res_q [$];
  int          lat_q [$];

  // Scoreboard side: every observed write and every Ack rise consumes an expectation.
  int   busy_t = 0;
  logic prev_busy = 1'b0;
  logic prev_ack = 1'b0;
  always @(negedge Clk) begin
    if (MemWrEn) begin
      if (wr_q.size() == 0) chk("spurious_wr", {16'h0, MemAddr, MemDataOut}, 32'h0);
      else chk("wr_addr_data", {16'h0, MemAddr, MemDataOut}, {16'h0, wr_q.pop_front()});
    end
    if (Busy && !prev_busy) busy_t = cyc;
    if (Ack && !prev_ack) begin
      if (res_q.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
      else begin
        chk("ack_latency", 32'(cyc - busy_t), 32'(lat_q.pop_front()));
        chk("result_bytes", {8'h0, mem[4], mem[5], mem[6]}, {8'h0, res_q.pop_front()});
      end
    end
    prev_busy = Busy;
    prev_ack = Ack;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge Clk);
    tb_we = 1'b1; tb_addr = a; tb_dat = v;
    @(posedge Clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] dvd, input logic [7:0] dvs);
    poke(8'd0, dvd[15:8]);
    poke(8'd1, dvd[7:0]);
    poke(8'd2, dvs);
    for (int i = 4; i < 7; i++) poke(8'(i), 8'hEE);
  endtask

  // Start 1 then 0; the edge after Start drops is E0.
  task automatic kick();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    chk("ack_clear", 32'(Ack), 32'd0);
    Start = 1'b0;
  endtask

  task automatic run(input logic [15:0] dvd, input logic [7:0] dvs, input bit toggle);
    logic [23:0] exp;
    int n;
    load(dvd, dvs);
    exp = (dvs == 8'd0) ? 24'hFFFFFF : 24'(({dvd, 8'h00}) / {16'h0, dvs});
    res_q.push_back(exp);
    lat_q.push_back((dvs == 8'd0) ? 7 : 31);
    wr_q.push_back({8'd4, exp[23:16]});
    wr_q.push_back({8'd5, exp[15:8]});
    wr_q.push_back({8'd6, exp[7:0]});
    kick();
    n = 0;
    while (!Ack && n < 80) begin
      @(negedge Clk);
      n++;
      if (toggle && n == 10) Start = 1'b1;
      if (toggle && n == 12) Start = 1'b0;
      if (toggle && n == 13) Start = 1'b1;
      if (toggle && n == 14) Start = 1'b0;
    end
    if (!Ack) chk("ack_timeout", 32'd0, 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_dat = '0;
    #3 Reset = 1'b1;
    #1;
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_wren", 32'(MemWrEn), 32'd0);
    chk("rst_addr", 32'(MemAddr), 32'd0);
    chk("rst_dout", 32'(MemDataOut), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Start held low: nothing happens.
    repeat (100) @(negedge Clk);
    chk("idle_busy", 32'(Busy), 32'd0);
    chk("idle_ack", 32'(Ack), 32'd0);
    chk("idle_addr", 32'(MemAddr), 32'd0);

    run(16'd385, 8'd6, 1'b0);
    run(16'd3, 8'd255, 1'b0);
    run(16'd1, 8'd255, 1'b0);
    run(16'd65535, 8'd1, 1'b0);
    run(16'd1234, 8'd0, 1'b0);

    // Reset mid-divide: outputs drop before the next edge, result bytes untouched.
    load(16'd385, 8'd6);
    kick();
    repeat (16) @(posedge Clk);
    #2;
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(Ack), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_wren", 32'(MemWrEn), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    chk("mid_rst_bytes", {8'h0, mem[4], mem[5], mem[6]}, 32'h00EEEEEE);
    chk("mid_rst_ack_after", 32'(Ack), 32'd0);

    run(16'd385, 8'd6, 1'b0);
    // Back-to-back from DONE with Start wiggling mid-run.
    run(16'd200, 8'd7, 1'b1);
    chk("final_ack", 32'(Ack), 32'd1);

    repeat (5) @(negedge Clk);
    chk("sb_wr_left", 32'(wr_q.size()), 32'd0);
    chk("sb_res_left", 32'(res_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
